// File: rtl/dmem_if.sv
// CPU-to-data-memory bus: enables, byte address, store data, access type and load data.
// Purely combinational wiring; no latency of its own.
// No backpressure: the memory answers every access in the cycle it is presented.
interface dmem_if;
    logic        mem_w;     // store enable
    logic        MemRead;   // load enable
    logic [31:0] Addr_in;   // byte address
    logic [31:0] Data_in;   // store data (low byte/half used for sub-word stores)
    logic [2:0]  DMType;    // 000 word, 001 half s, 010 half u, 011 byte s, 100 byte u
    logic [31:0] Data_out;  // load data, combinational

    // CPU side drives the request and receives the load data
    modport master (
        output mem_w,
        output MemRead,
        output Addr_in,
        output Data_in,
        output DMType,
        input  Data_out
    );

    // Memory side receives the request and returns the load data
    modport slave (
        input  mem_w,
        input  MemRead,
        input  Addr_in,
        input  Data_in,
        input  DMType,
        output Data_out
    );
endinterface

// File: rtl/dmem_unit.sv
// Data memory stage: word RAM with byte-lane stores, load extension, MMIO window, sticky fault capture.
// Latency: loads combinational in the same cycle; stores and register updates land on the next rising edge.
// Backpressure: none; every access completes immediately, faulting accesses are dropped and recorded.
module dmem_unit #(
    parameter int          DEPTH     = 1024,
    parameter logic [31:0] MMIO_BASE = 32'hFFFF0000
) (
    input  logic        clk,
    input  logic        reset,
    dmem_if.slave       bus,
    input  logic [15:0] sw,
    output logic [15:0] led,
    output logic        err,
    output logic [1:0]  err_cause,
    output logic [31:0] err_addr
);
    localparam int IW = $clog2(DEPTH);

    typedef enum logic [1:0] {
        CAUSE_NONE     = 2'b00,
        CAUSE_MISALIGN = 2'b01,
        CAUSE_UNMAPPED = 2'b10,
        CAUSE_DMTYPE   = 2'b11
    } cause_e;

    // MMIO register offsets, indexed by Addr_in[3:2]
    localparam logic [1:0] MMIO_CYCLE = 2'd0;
    localparam logic [1:0] MMIO_LED   = 2'd1;
    localparam logic [1:0] MMIO_SW    = 2'd2;
    localparam logic [1:0] MMIO_STCNT = 2'd3;

    logic [31:0]   ram [DEPTH];
    logic [31:0]   cycle_cnt;
    logic [31:0]   store_cnt;

    logic [31:0]   addr;
    logic [2:0]    dm_type;
    logic          access;
    logic          is_word;
    logic          is_half;
    logic          is_byte;
    logic          is_signed;
    logic          ram_hit;
    logic          mmio_hit;
    logic          misaligned;
    cause_e        cause;
    logic          fault;
    logic          ram_we;
    logic          mmio_we;
    logic [IW-1:0] word_idx;
    logic [1:0]    mmio_off;
    logic [3:0]    lane_mask;
    logic [31:0]   lane_dat;
    logic [31:0]   ram_rd;
    logic [15:0]   half_sel;
    logic [7:0]    byte_sel;
    logic [31:0]   ram_load;
    logic [31:0]   mmio_load;

    assign addr     = bus.Addr_in;
    assign dm_type  = bus.DMType;
    assign access   = bus.mem_w | bus.MemRead;
    assign word_idx = addr[IW+1:2];
    assign mmio_off = addr[3:2];

    // Access-type decode; anything outside 000..100 is an illegal DMType
    always_comb begin
        is_word   = 1'b0;
        is_half   = 1'b0;
        is_byte   = 1'b0;
        is_signed = 1'b0;
        case (dm_type)
            3'b000: is_word = 1'b1;
            3'b001: begin is_half = 1'b1; is_signed = 1'b1; end
            3'b010: is_half = 1'b1;
            3'b011: begin is_byte = 1'b1; is_signed = 1'b1; end
            3'b100: is_byte = 1'b1;
            default: ;
        endcase
    end

    // Address map: RAM occupies the bottom DEPTH*4 bytes, MMIO a 16-byte window
    assign ram_hit  = (addr[31:IW+2] == '0);
    assign mmio_hit = (addr[31:4] == MMIO_BASE[31:4]);

    // MMIO registers are word-only, so a sub-word MMIO access is treated as misaligned
    assign misaligned = (is_word & (addr[1:0] != 2'b00))
                      | (is_half & addr[0])
                      | (mmio_hit & ~is_word);

    // Fault classification, highest priority first: DMType, unmapped, misaligned
    always_comb begin
        cause = CAUSE_NONE;
        if (!(is_word | is_half | is_byte)) begin
            cause = CAUSE_DMTYPE;
        end else if (!(ram_hit | mmio_hit)) begin
            cause = CAUSE_UNMAPPED;
        end else if (misaligned) begin
            cause = CAUSE_MISALIGN;
        end
    end

    // Only a presented access can fault; an idle bus carries a don't-care address
    assign fault = access & (cause != CAUSE_NONE);

    // A store landing on the same edge that reset is low is dropped
    assign ram_we  = reset & bus.mem_w & ram_hit & ~fault;
    assign mmio_we = bus.mem_w & mmio_hit & ~fault;

    // Byte-lane enables and replicated store data so each lane picks up the right bits
    always_comb begin
        lane_mask = 4'b0000;
        lane_dat  = bus.Data_in;
        if (is_word) begin
            lane_mask = 4'b1111;
        end else if (is_half) begin
            lane_mask = addr[1] ? 4'b1100 : 4'b0011;
            lane_dat  = {2{bus.Data_in[15:0]}};
        end else if (is_byte) begin
            lane_mask = 4'b0001 << addr[1:0];
            lane_dat  = {4{bus.Data_in[7:0]}};
        end
    end

    // RAM array write; contents survive reset
    always_ff @(posedge clk) begin
        if (ram_we) begin
            for (int b = 0; b < 4; b++) begin
                if (lane_mask[b]) begin
                    ram[word_idx][8*b +: 8] <= lane_dat[8*b +: 8];
                end
            end
        end
    end

    assign ram_rd = ram[word_idx];

    // Pick the addressed half/byte out of the RAM word
    always_comb begin
        half_sel = addr[1] ? ram_rd[31:16] : ram_rd[15:0];
        case (addr[1:0])
            2'd0:    byte_sel = ram_rd[7:0];
            2'd1:    byte_sel = ram_rd[15:8];
            2'd2:    byte_sel = ram_rd[23:16];
            default: byte_sel = ram_rd[31:24];
        endcase
    end

    // Sign or zero extension of the selected RAM lanes
    always_comb begin
        ram_load = ram_rd;
        if (is_half) begin
            ram_load = {{16{is_signed & half_sel[15]}}, half_sel};
        end else if (is_byte) begin
            ram_load = {{24{is_signed & byte_sel[7]}}, byte_sel};
        end
    end

    // MMIO read mux; the cycle counter shows its value before this cycle's increment
    always_comb begin
        case (mmio_off)
            MMIO_CYCLE: mmio_load = cycle_cnt;
            MMIO_LED:   mmio_load = {16'h0000, led};
            MMIO_SW:    mmio_load = {16'h0000, sw};
            default:    mmio_load = store_cnt;
        endcase
    end

    // Load data: zero unless a clean load is presented
    always_comb begin
        bus.Data_out = 32'h0000_0000;
        if (bus.MemRead && !fault) begin
            bus.Data_out = ram_hit ? ram_load : mmio_load;
        end
    end

    // Free-running cycle counter, wraps naturally
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cycle_cnt <= 32'h0000_0000;
        end else begin
            cycle_cnt <= cycle_cnt + 32'd1;
        end
    end

    // Store counter: saturating count of RAM stores, cleared by a store to its own address
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            store_cnt <= 32'h0000_0000;
        end else if (mmio_we && (mmio_off == MMIO_STCNT)) begin
            store_cnt <= 32'h0000_0000;
        end else if (ram_we && (store_cnt != 32'hFFFF_FFFF)) begin
            store_cnt <= store_cnt + 32'd1;
        end
    end

    // LED register, written by a word store to its MMIO slot
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            led <= 16'h0000;
        end else if (mmio_we && (mmio_off == MMIO_LED)) begin
            led <= bus.Data_in[15:0];
        end
    end

    // Sticky fault capture; the first fault's cause and address are kept until reset
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            err       <= 1'b0;
            err_cause <= CAUSE_NONE;
            err_addr  <= 32'h0000_0000;
        end else if (fault) begin
            err <= 1'b1;
            if (!err) begin
                err_cause <= cause;
                err_addr  <= addr;
            end
        end
    end

endmodule

// File: tb/tb_dmem_unit.sv
// Self-checking bench for dmem_unit: byte-level reference model plus directed vectors.
// Inputs change 2 time units after each rising edge; outputs are compared on the falling edge.
// No backpressure exists on this bus, so every vector completes in one cycle.
module tb_dmem_unit;
    localparam int          DEPTH     = 1024;
    localparam logic [31:0] MB        = 32'hFFFF0000;
    localparam logic [31:0] RAM_BYTES = 32'(DEPTH * 4);

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [15:0] sw = 16'h0000;
    logic [15:0] led;
    logic        err;
    logic [1:0]  err_cause;
    logic [31:0] err_addr;

    int checks = 0;
    int errors = 0;

    dmem_if bus();

    dmem_unit #(.DEPTH(DEPTH), .MMIO_BASE(MB)) dut (
        .clk       (clk),
        .reset     (rst_n),
        .bus       (bus),
        .sw        (sw),
        .led       (led),
        .err       (err),
        .err_cause (err_cause),
        .err_addr  (err_addr)
    );

    always #5 clk = ~clk;

    // Reference state: memory as a flat byte array with a written flag per byte
    logic [7:0]  mb [DEPTH*4];
    bit          mk [DEPTH*4];
    logic [15:0] m_led   = 16'h0;
    logic        m_err   = 1'b0;
    logic [1:0]  m_cause = 2'b0;
    logic [31:0] m_eaddr = 32'h0;
    logic [31:0] m_cyc   = 32'h0;
    logic [31:0] m_stc   = 32'h0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int m_size(input logic [2:0] t);
        if (t == 3'd0) return 4;
        if (t == 3'd1 || t == 3'd2) return 2;
        return 1;
    endfunction

    function automatic bit in_mmio(input logic [31:0] a);
        return (a >= MB) && ((a - MB) < 32'd16);
    endfunction

    // 0 ok, 1 misaligned, 2 unmapped, 3 illegal type
    function automatic logic [1:0] m_fault(input logic [31:0] a, input logic [2:0] t);
        int sz;
        if (t > 3'd4) return 2'd3;
        sz = m_size(t);
        if (!(a < RAM_BYTES) && !in_mmio(a)) return 2'd2;
        if (in_mmio(a) && sz != 4) return 2'd1;
        if ((a & 32'(sz - 1)) != 32'd0) return 2'd1;
        return 2'd0;
    endfunction

    function automatic logic [31:0] m_dout();
        logic [31:0] a;
        logic [31:0] v;
        int          sz;
        a = bus.Addr_in;
        v = 32'h0;
        if (!bus.MemRead || m_fault(a, bus.DMType) != 2'd0) return 32'h0;
        if (a < RAM_BYTES) begin
            sz = m_size(bus.DMType);
            for (int k = 0; k < sz; k++) v[8*k +: 8] = mb[int'(a) + k];
            if (bus.DMType == 3'd1) v = {{16{v[15]}}, v[15:0]};
            if (bus.DMType == 3'd3) v = {{24{v[7]}}, v[7:0]};
            return v;
        end
        case (a - MB)
            32'd0:   return m_cyc;
            32'd4:   return {16'h0, m_led};
            32'd8:   return {16'h0, sw};
            default: return m_stc;
        endcase
    endfunction

    // A RAM load is only predictable when every byte it touches was written
    function automatic bit m_known();
        logic [31:0] a;
        a = bus.Addr_in;
        if (!bus.MemRead || m_fault(a, bus.DMType) != 2'd0 || !(a < RAM_BYTES)) return 1'b1;
        for (int k = 0; k < m_size(bus.DMType); k++) if (!mk[int'(a) + k]) return 1'b0;
        return 1'b1;
    endfunction

    // Model update on each edge from the request presented during the cycle
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_led   <= 16'h0;
            m_err   <= 1'b0;
            m_cause <= 2'b0;
            m_eaddr <= 32'h0;
            m_cyc   <= 32'h0;
            m_stc   <= 32'h0;
        end else begin
            m_cyc <= m_cyc + 32'd1;
            if ((bus.mem_w || bus.MemRead) && m_fault(bus.Addr_in, bus.DMType) != 2'd0) begin
                m_err <= 1'b1;
                if (!m_err) begin
                    m_cause <= m_fault(bus.Addr_in, bus.DMType);
                    m_eaddr <= bus.Addr_in;
                end
            end else if (bus.mem_w) begin
                if (bus.Addr_in < RAM_BYTES) begin
                    for (int k = 0; k < m_size(bus.DMType); k++) begin
                        mb[int'(bus.Addr_in) + k] <= bus.Data_in[8*k +: 8];
                        mk[int'(bus.Addr_in) + k] <= 1'b1;
                    end
                    if (m_stc != 32'hFFFF_FFFF) m_stc <= m_stc + 32'd1;
                end else if (bus.Addr_in - MB == 32'd4) begin
                    m_led <= bus.Data_in[15:0];
                end else if (bus.Addr_in - MB == 32'd12) begin
                    m_stc <= 32'h0;
                end
            end
        end
    end

    // Compare every output against the model in mid-cycle
    always @(negedge clk) begin
        check("led", {16'h0, led}, {16'h0, m_led});
        check("err", {31'h0, err}, {31'h0, m_err});
        check("err_cause", {30'h0, err_cause}, {30'h0, m_cause});
        check("err_addr", err_addr, m_eaddr);
        if (m_known()) check("data_out", bus.Data_out, m_dout());
    end

    task automatic drive(input bit we, input bit re, input logic [31:0] a,
                         input logic [31:0] d, input logic [2:0] t);
        @(posedge clk);
        #2;
        bus.mem_w   = we;
        bus.MemRead = re;
        bus.Addr_in = a;
        bus.Data_in = d;
        bus.DMType  = t;
    endtask

    task automatic st(input logic [31:0] a, input logic [31:0] d, input logic [2:0] t);
        drive(1'b1, 1'b0, a, d, t);
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 32'h0, 32'h0, 3'd0);
    endtask

    // Load with a hand-computed expectation, pinning both the DUT and the model
    task automatic ld(input string name, input logic [31:0] a, input logic [2:0] t,
                      input logic [31:0] exp);
        drive(1'b0, 1'b1, a, 32'h0, t);
        #2;
        check(name, bus.Data_out, exp);
        check({name, "_model"}, m_dout(), exp);
    endtask

    logic [31:0] v1;
    logic [31:0] v2;

    initial begin
        bus.mem_w   = 1'b0;
        bus.MemRead = 1'b0;
        bus.Addr_in = 32'h0;
        bus.Data_in = 32'h0;
        bus.DMType  = 3'd0;
        #1 rst_n = 1'b0;
        #20 rst_n = 1'b1;
        @(negedge clk);
        check("rst_led", {16'h0, led}, 32'h0);
        check("rst_err", {31'h0, err}, 32'h0);
        check("rst_addr", err_addr, 32'h0);
        ld("rst_stcnt", 32'hFFFF000C, 3'd0, 32'h0);

        // Word store then loads
        st(32'h10, 32'h12345678, 3'd0);
        ld("word_10", 32'h10, 3'd0, 32'h12345678);
        ld("stcnt_1", 32'hFFFF000C, 3'd0, 32'h1);

        // Byte store into the middle of a word
        st(32'h11, 32'h000000AB, 3'd4);
        ld("lb_11", 32'h11, 3'd3, 32'hFFFFFFAB);
        ld("lbu_11", 32'h11, 3'd4, 32'h000000AB);
        ld("word_merge", 32'h10, 3'd0, 32'h1234AB78);

        // Upper half store, then signed/unsigned half loads
        st(32'h12, 32'hFFFF8001, 3'd2);
        ld("lh_12", 32'h12, 3'd1, 32'hFFFF8001);
        ld("lhu_12", 32'h12, 3'd2, 32'h00008001);
        ld("lhu_10", 32'h10, 3'd2, 32'h0000AB78);

        // Misaligned store: dropped and recorded
        st(32'h20, 32'hCAFEF00D, 3'd0);
        st(32'h22, 32'h11111111, 3'd0);
        idle();
        #2;
        check("mis_err", {31'h0, err}, 32'h1);
        check("mis_cause", {30'h0, err_cause}, 32'h1);
        check("mis_addr", err_addr, 32'h22);
        ld("ram_kept", 32'h20, 3'd0, 32'hCAFEF00D);

        // Later faults return zero and leave the first record in place
        ld("unmapped", 32'h00100000, 3'd0, 32'h0);
        ld("bad_type", 32'h10, 3'd5, 32'h0);
        ld("mmio_sub", 32'hFFFF0004, 3'd2, 32'h0);
        idle();
        #2;
        check("first_cause", {30'h0, err_cause}, 32'h1);
        check("first_addr", err_addr, 32'h22);

        // MMIO: LED, switches, cycle counter
        st(32'hFFFF0004, 32'h0000BEEF, 3'd0);
        idle();
        #2;
        check("led_beef", {16'h0, led}, 32'h0000BEEF);
        sw = 16'h00A5;
        ld("switches", 32'hFFFF0008, 3'd0, 32'h000000A5);
        drive(1'b0, 1'b1, 32'hFFFF0000, 32'h0, 3'd0);
        #2 v1 = bus.Data_out;
        repeat (4) idle();
        drive(1'b0, 1'b1, 32'hFFFF0000, 32'h0, 3'd0);
        #2 v2 = bus.Data_out;
        check("cyc_delta", v2 - v1, 32'd5);

        // Store counter: four RAM stores so far, then cleared by a store to itself
        ld("stcnt_4", 32'hFFFF000C, 3'd0, 32'h4);
        st(32'hFFFF000C, 32'h0, 3'd0);
        ld("stcnt_clr", 32'hFFFF000C, 3'd0, 32'h0);

        // Both enables: store happens, load shows the old word, next cycle shows the new
        drive(1'b1, 1'b1, 32'h10, 32'h55667788, 3'd0);
        #2;
        check("both_old", bus.Data_out, 32'h8001AB78);
        ld("raw_new", 32'h10, 3'd0, 32'h55667788);
        ld("stcnt_1b", 32'hFFFF000C, 3'd0, 32'h1);

        // Asynchronous reset between edges, with a store pending across the edge
        @(posedge clk);
        #2;
        bus.mem_w   = 1'b1;
        bus.MemRead = 1'b0;
        bus.Addr_in = 32'h10;
        bus.Data_in = 32'hDEADDEAD;
        bus.DMType  = 3'd0;
        #1 rst_n = 1'b0;
        #1;
        check("arst_led", {16'h0, led}, 32'h0);
        check("arst_err", {31'h0, err}, 32'h0);
        check("arst_cause", {30'h0, err_cause}, 32'h0);
        check("arst_addr", err_addr, 32'h0);
        bus.mem_w   = 1'b0;
        bus.MemRead = 1'b1;
        bus.Addr_in = 32'hFFFF0000;
        #1 check("arst_cyc", bus.Data_out, 32'h0);
        bus.Addr_in = 32'hFFFF000C;
        #1 check("arst_stcnt", bus.Data_out, 32'h0);
        bus.mem_w   = 1'b1;
        bus.MemRead = 1'b0;
        bus.Addr_in = 32'h10;
        @(posedge clk);
        #2;
        bus.mem_w = 1'b0;
        #1 rst_n = 1'b1;
        ld("ram_survives", 32'h10, 3'd0, 32'h55667788);
        ld("byte_survives", 32'h23, 3'd4, 32'h000000CA);
        idle();
        @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete, got running, expected finished");
        $fatal(1);
    end

endmodule
